// File: rtl/fp16_pkg.sv
// Shared FP16 constants, flag indices and operand classification for the FP16 x INTn multipliers.
package fp16_pkg;

   localparam int FP_W     = 16;
   localparam int EXP_W    = 5;
   localparam int FRAC_W   = 10;
   localparam int EXP_BIAS = 15;
   localparam int EXP_MAX  = 31;

   localparam logic [FP_W-1:0] QNAN       = 16'h7E00;
   localparam logic [FP_W-1:0] POS_INF    = 16'h7C00;
   localparam logic [FP_W-1:0] MAX_FINITE = 16'h7BFF;

   localparam int FLG_OVF = 0;
   localparam int FLG_INV = 1;

   typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_t;

   // Subnormals are reported as ZERO: the multiplier flushes them.
   function automatic fp_class_t fp16_class(input logic [FP_W-1:0] a);
      if (a[FP_W-2 -: EXP_W] == EXP_W'(EXP_MAX))
         return (a[FRAC_W-1:0] != '0) ? NAN : INF;
      if (a[FP_W-2 -: EXP_W] == '0)
         return ZERO;
      return NORM;
   endfunction

endpackage

// File: rtl/fp16_intn_mul_lane.sv
// One lane of the FP16 x signed INT_W multiplier: unpack, multiply, normalise/round/pack registers.
// FP16_MUL_SAT_EN: when defined, overflow returns +/-MAX_FINITE instead of +/-Inf.
module fp16_intn_mul_lane
   import fp16_pkg::*;
#(
   parameter int INT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_s0,
   input  logic             ld_s1,
   input  logic             ld_s2,
   input  logic [FP_W-1:0]  a,
   input  logic [INT_W-1:0] b,
   output logic [FP_W-1:0]  res,
   output logic [1:0]       flags
);

   localparam int PW = 11 + INT_W;
   localparam logic [4:0] TOP = 5'(PW - 1);

   logic              s0_sa, s0_sb;
   logic [EXP_W-1:0]  s0_exp;
   logic [FRAC_W-1:0] s0_frac;
   logic [INT_W-1:0]  s0_abs;
   fp_class_t         s0_cls;

   logic              s1_sign, s1_izero;
   logic [EXP_W-1:0]  s1_exp;
   logic [PW-1:0]     s1_prod;
   fp_class_t         s1_cls;

   logic [4:0]        lead;
   logic [PW-2:0]     norm;
   logic [FRAC_W-1:0] mant;
   logic              guard, sticky;
   logic [FRAC_W:0]   rnd;
   logic [6:0]        exp_sum;
   logic [FP_W-1:0]   res_d;
   logic [1:0]        flg_d;

   // Most negative INT_W value magnitude (2^(INT_W-1)) still fits the unsigned field.
   logic [INT_W-1:0] b_abs;
   assign b_abs = b[INT_W-1] ? INT_W'(-b) : b;

   always_comb begin
      lead = '0;
      for (int i = 0; i < PW; i++)
         if (s1_prod[i]) lead = 5'(i);
      // Left-justify the product; the hidden one falls off the top in the cast.
      norm    = (PW-1)'(s1_prod << (TOP - lead));
      mant    = norm[PW-2 -: FRAC_W];
      guard   = norm[PW-12];
      sticky  = |norm[PW-13:0];
      rnd     = {1'b0, mant} + (FRAC_W+1)'(guard && (sticky || mant[0]));
      exp_sum = 7'(s1_exp) + 7'(lead - 5'd10) + 7'(rnd[FRAC_W]);

      res_d = '0;
      flg_d = '0;
      if (s1_cls == NAN) begin
         res_d = QNAN;
      end else if (s1_cls == INF && s1_izero) begin
         res_d          = QNAN;
         flg_d[FLG_INV] = 1'b1;
      end else if (s1_cls == INF) begin
         res_d = POS_INF | {s1_sign, 15'b0};
      end else if (s1_cls == ZERO || s1_izero) begin
         res_d = {s1_sign, 15'b0};
      end else if (exp_sum >= 7'(EXP_MAX)) begin
         flg_d[FLG_OVF] = 1'b1;
`ifdef FP16_MUL_SAT_EN
         res_d = MAX_FINITE | {s1_sign, 15'b0};
`else
         res_d = POS_INF | {s1_sign, 15'b0};
`endif
      end else begin
         res_d = {s1_sign, exp_sum[EXP_W-1:0], rnd[FRAC_W-1:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_sa    <= 1'b0;
         s0_sb    <= 1'b0;
         s0_exp   <= '0;
         s0_frac  <= '0;
         s0_abs   <= '0;
         s0_cls   <= ZERO;
         s1_sign  <= 1'b0;
         s1_izero <= 1'b0;
         s1_exp   <= '0;
         s1_prod  <= '0;
         s1_cls   <= ZERO;
         res      <= '0;
         flags    <= '0;
      end else begin
         if (ld_s0) begin
            s0_sa   <= a[FP_W-1];
            s0_sb   <= b[INT_W-1];
            s0_exp  <= a[FP_W-2 -: EXP_W];
            s0_frac <= a[FRAC_W-1:0];
            s0_abs  <= b_abs;
            s0_cls  <= fp16_class(a);
         end
         if (ld_s1) begin
            s1_sign  <= s0_sa ^ s0_sb;
            s1_izero <= (s0_abs == '0);
            s1_exp   <= s0_exp;
            s1_prod  <= PW'({1'b1, s0_frac}) * PW'(s0_abs);
            s1_cls   <= s0_cls;
         end
         if (ld_s2) begin
            res   <= res_d;
            flags <= flg_d;
         end
      end
   end

endmodule

// File: rtl/fp16_intn_mul_vec.sv
// LANES-wide FP16 x signed INT_W multiplier, 3 register stages behind one shared valid/ready handshake.
// FP16_MUL_SAT_EN: when defined, overflow saturates to +/-MAX_FINITE (flag still set).
module fp16_intn_mul_vec
   import fp16_pkg::*;
#(
   parameter int LANES = 4,
   parameter int INT_W = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FP_W*LANES-1:0]  in_fp16,
   input  logic [INT_W*LANES-1:0] in_int,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FP_W*LANES-1:0]  out_fp16,
   output logic [2*LANES-1:0]     out_flags
);

   logic v0, v1;
   logic rdy0, rdy1, rdy_out;

   // Each stage may accept whenever it is empty or its successor takes its data this cycle.
   assign rdy_out  = !out_valid || out_ready;
   assign rdy1     = !v1 || rdy_out;
   assign rdy0     = !v0 || rdy1;
   assign in_ready = rdy0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (rdy0)    v0        <= in_valid;
         if (rdy1)    v1        <= v0;
         if (rdy_out) out_valid <= v1;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fp16_intn_mul_lane #(
         .INT_W (INT_W)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .ld_s0 (in_valid && rdy0),
         .ld_s1 (v0 && rdy1),
         .ld_s2 (v1 && rdy_out),
         .a     (in_fp16[FP_W*i +: FP_W]),
         .b     (in_int[INT_W*i +: INT_W]),
         .res   (out_fp16[FP_W*i +: FP_W]),
         .flags (out_flags[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_fp16_intn_mul_vec.sv
// Self-checking bench for fp16_intn_mul_vec: integer-arithmetic reference model plus directed vectors.
module tb_fp16_intn_mul_vec;

   localparam int LANES = 4;
   localparam int INT_W = 4;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   in_valid;
   logic                   in_ready;
   logic [16*LANES-1:0]    in_fp16;
   logic [INT_W*LANES-1:0] in_int;
   logic                   out_valid;
   logic                   out_ready;
   logic [16*LANES-1:0]    out_fp16;
   logic [2*LANES-1:0]     out_flags;

   always #5 clk = ~clk;

   fp16_intn_mul_vec #(.LANES(LANES), .INT_W(INT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fp16   (in_fp16),
      .in_int    (in_int),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fp16  (out_fp16),
      .out_flags (out_flags)
   );

   typedef struct {
      logic [16*LANES-1:0] r;
      logic [2*LANES-1:0]  f;
      int                  cyc;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   n_deliv = 0;
   bit   lat_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // Value = (1024+frac) * |b| * 2^(exp-25); round that integer to 11 significant bits, ties to even.
   function automatic void model(input logic [15:0] a, input int b, output logic [15:0] r,
                                 output logic [1:0] f);
      int e, fr, mag, p, sh, q, rem, half;
      logic s;
      e   = int'(a[14:10]);
      fr  = int'(a[9:0]);
      s   = a[15] ^ (b < 0);
      mag = (b < 0) ? -b : b;
      r   = 16'h0;
      f   = 2'b00;
      if (e == 31 && fr != 0) begin
         r = 16'h7E00;
      end else if (e == 31) begin
         if (b == 0) begin
            r = 16'h7E00;
            f = 2'b10;
         end else begin
            r = {s, 15'h7C00};
         end
      end else if (e == 0 || b == 0) begin
         r = {s, 15'h0};
      end else begin
         p  = (1024 + fr) * mag;
         sh = 0;
         while ((p >> sh) >= 2048) sh++;
         q   = p >> sh;
         rem = p - (q << sh);
         if (sh > 0) begin
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
         end
         if (q == 2048) begin
            q = 1024;
            sh++;
         end
         if (e + sh >= 31) begin
            f = 2'b01;
`ifdef FP16_MUL_SAT_EN
            r = {s, 15'h7BFF};
`else
            r = {s, 15'h7C00};
`endif
         end else begin
            r = {s, 5'(e + sh), 10'(q - 1024)};
         end
      end
   endfunction

   task automatic pin(input string nm, input logic [15:0] a, input int b,
                      input logic [15:0] er, input logic [1:0] ef);
      logic [15:0] r;
      logic [1:0]  f;
      model(a, b, r, f);
      chk({nm, "_res"}, 64'(r), 64'(er));
      chk({nm, "_flg"}, 64'(f), 64'(ef));
   endtask

   function automatic exp_t expect_txn(input logic [16*LANES-1:0] a, input logic [INT_W*LANES-1:0] b);
      exp_t        e;
      logic [15:0] r;
      logic [1:0]  f;
      logic signed [INT_W-1:0] bl;
      for (int l = 0; l < LANES; l++) begin
         bl = b[INT_W*l +: INT_W];
         model(a[16*l +: 16], int'(bl), r, f);
         e.r[16*l +: 16] = r;
         e.f[2*l +: 2]   = f;
      end
      e.cyc = cyc;
      return e;
   endfunction

   task automatic send(input logic [16*LANES-1:0] a, input logic [INT_W*LANES-1:0] b);
      int w;
      w = 0;
      @(negedge clk);
      in_fp16  = a;
      in_int   = b;
      in_valid = 1'b1;
      #4;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         #4;
         w++;
      end
      if (in_ready) expq.push_back(expect_txn(a, b));
      else chk("accept_timeout", 64'(in_ready), 64'd1);
   endtask

   task automatic drain(input string nm);
      int w;
      w = 0;
      while (expq.size() != 0 && w < 60) begin
         @(negedge clk);
         w++;
      end
      chk(nm, 64'(expq.size()), 64'd0);
   endtask

   // Checker: samples just before each rising edge, when the handshake outcome is settled.
   initial begin
      bit                  stalled;
      logic [16*LANES-1:0] hold_r;
      logic [2*LANES-1:0]  hold_f;
      exp_t                e;
      stalled = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               chk("hold_valid", 64'(out_valid), 64'd1);
               chk("hold_fp16", 64'(out_fp16), 64'(hold_r));
               chk("hold_flags", 64'(out_flags), 64'(hold_f));
            end
            if (out_valid && out_ready) begin
               if (expq.size() == 0) begin
                  chk("unexpected_output", 64'(out_valid), 64'd0);
               end else begin
                  e = expq.pop_front();
                  n_deliv++;
                  for (int l = 0; l < LANES; l++) begin
                     chk($sformatf("lane%0d_fp16", l), 64'(out_fp16[16*l +: 16]), 64'(e.r[16*l +: 16]));
                     chk($sformatf("lane%0d_flags", l), 64'(out_flags[2*l +: 2]), 64'(e.f[2*l +: 2]));
                  end
                  if (lat_chk && !stalled) chk("latency", 64'(cyc - e.cyc), 64'd3);
               end
               stalled = 1'b0;
            end else if (out_valid) begin
               stalled = 1'b1;
               hold_r  = out_fp16;
               hold_f  = out_flags;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_fp16   = '0;
      in_int    = '0;
      out_ready = 1'b1;

      // Model pins from hand-computed values.
      pin("pin_1p5x3", 16'h3E00, 3, 16'h4480, 2'b00);
      pin("pin_1xm8", 16'h3C00, -8, 16'hC800, 2'b00);
      pin("pin_maxmx7", 16'h3FFF, 7, 16'h4AFF, 2'b00);
      pin("pin_tie", 16'h3C01, 3, 16'h4202, 2'b00);
      pin("pin_negzero", 16'hBC00, 0, 16'h8000, 2'b00);
      pin("pin_sub", 16'h0001, 5, 16'h0000, 2'b00);
`ifdef FP16_MUL_SAT_EN
      pin("pin_ovf", 16'h7BFF, 2, 16'h7BFF, 2'b01);
`else
      pin("pin_ovf", 16'h7BFF, 2, 16'h7C00, 2'b01);
`endif
      pin("pin_nan", 16'h7E00, 3, 16'h7E00, 2'b00);
      pin("pin_infx0", 16'h7C00, 0, 16'h7E00, 2'b10);
      pin("pin_ninfxm1", 16'hFC00, -1, 16'h7C00, 2'b00);

      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_fp16", 64'(out_fp16), 64'd0);
      chk("rst_out_flags", 64'(out_flags), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Directed transactions, out_ready held high.
      lat_chk = 1'b1;
      send({16'h3C01, 16'h3FFF, 16'h3C00, 16'h3E00}, {4'h3, 4'h7, 4'h8, 4'h3});
      send({16'h7E00, 16'h7BFF, 16'h0001, 16'hBC00}, {4'h3, 4'h2, 4'h5, 4'h0});
      send({16'h3555, 16'h7C00, 16'hFC00, 16'h7C00}, {4'hF, 4'h8, 4'hF, 4'h0});
      send({16'h0400, 16'h2E66, 16'hC123, 16'h5A3C}, {4'h6, 4'hD, 4'h5, 4'h9});
      @(negedge clk);
      in_valid = 1'b0;
      drain("directed_drain");

      // Backpressure: 10-transaction stream with out_ready low for 5 cycles.
      lat_chk = 1'b0;
      d0 = n_deliv;
      @(negedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               logic [16*LANES-1:0]    a;
               logic [INT_W*LANES-1:0] b;
               for (int l = 0; l < LANES; l++) begin
                  a[16*l +: 16]       = 16'h3400 + 16'(i * 16'h0131 + l * 16'h0257);
                  b[INT_W*l +: INT_W] = INT_W'(i * 5 + l * 3);
               end
               send(a, b);
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            repeat (6) @(negedge clk);
            out_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               #4;
               chk("bp_in_ready", 64'(in_ready), 64'd0);
               chk("bp_depth", 64'(expq.size()), 64'd3);
               @(negedge clk);
            end
            out_ready = 1'b1;
         end
      join
      drain("bp_drain");
      chk("bp_count", 64'(n_deliv - d0), 64'd10);

      // Reset with two transactions in flight.
      lat_chk = 1'b1;
      send({16'h3E00, 16'h3E00, 16'h3E00, 16'h3E00}, {4'h3, 4'h3, 4'h3, 4'h3});
      send({16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00}, {4'h5, 4'h5, 4'h5, 4'h5});
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_fp16", 64'(out_fp16), 64'd0);
      expq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 6; k++) begin
         chk("no_stale", 64'(out_valid), 64'd0);
         @(posedge clk);
         #1;
      end

      // One more transaction after reset to confirm the pipe still works.
      send({16'h3FFF, 16'h3C01, 16'h3C00, 16'h3E00}, {4'h7, 4'h3, 4'h8, 4'h3});
      @(negedge clk);
      in_valid = 1'b0;
      drain("post_rst_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
